// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback -- MEM/WB pipeline register and writeback logic of the RV32I core.
//
// Captures one instruction per clock from the MEM stage. In the following
// cycle it drives the register-file write port, reports one retire record and
// runs a RUN/HALT machine. The machine stops the core after the first
// instruction that traps (ebreak, illegal encoding or misaligned load). A
// counter tracks every instruction that retires without a trap.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid, i_flush    instruction present / discard incoming instruction
//   i_pc                instruction PC
//   i_alu_result        ALU result, also the load address
//   i_mem_rdata         raw data-memory word
//   i_funct3            load width / sign code
//   i_mem_to_reg        writeback source is load data
//   i_jump              writeback source is PC+4
//   i_reg_write         instruction writes rd
//   i_rd_waddr          destination register
//   i_ebreak, i_illegal trap sources from decode
//   WriteData/WriteAddr/WriteEn   register-file write port
//   o_retire_valid/o_retire_pc/o_trap  retire record
//   o_halt              core halted
//   o_instret           non-trapping retired instruction count
// ---------------------------------------------------------------------------
module writeback #(
  parameter int INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [31:0]          i_pc,
  input  logic [31:0]          i_alu_result,
  input  logic [31:0]          i_mem_rdata,
  input  logic [2:0]           i_funct3,
  input  logic                 i_mem_to_reg,
  input  logic                 i_jump,
  input  logic                 i_reg_write,
  input  logic [4:0]           i_rd_waddr,
  input  logic                 i_ebreak,
  input  logic                 i_illegal,
  output logic [31:0]          WriteData,
  output logic [4:0]           WriteAddr,
  output logic                 WriteEn,
  output logic                 o_retire_valid,
  output logic [31:0]          o_retire_pc,
  output logic                 o_trap,
  output logic                 o_halt,
  output logic [INSTRET_W-1:0] o_instret
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;

  // Stage registers
  logic                 s_valid;
  logic [31:0]          s_pc;
  logic [31:0]          s_alu_result;
  logic [31:0]          s_mem_rdata;
  logic [2:0]           s_funct3;
  logic                 s_mem_to_reg;
  logic                 s_jump;
  logic                 s_reg_write;
  logic [4:0]           s_rd_waddr;
  logic                 s_ebreak;
  logic                 s_illegal;
  logic [INSTRET_W-1:0] instret;

  // Derived combinational signals
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        bad_funct3;
  logic        misaligned;
  logic        s_trap;
  logic        running;
  logic        retire_ok;

  assign running = (state == RUN);

  // Load alignment: pick the byte/half addressed by the low address bits.
  always_comb begin
    load_byte = 8'h00;
    case (s_alu_result[1:0])
      2'd0: load_byte = s_mem_rdata[7:0];
      2'd1: load_byte = s_mem_rdata[15:8];
      2'd2: load_byte = s_mem_rdata[23:16];
      2'd3: load_byte = s_mem_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
  end

  assign load_half = s_alu_result[1] ? s_mem_rdata[31:16] : s_mem_rdata[15:0];

  always_comb begin
    load_data  = 32'h0000_0000;
    bad_funct3 = 1'b0;
    case (s_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h00_0000, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0000, load_half};
      3'b010:  load_data = s_mem_rdata;
      default: bad_funct3 = 1'b1;
    endcase
  end

  // Halfword loads need an even address, word loads a word-aligned one.
  always_comb begin
    misaligned = 1'b0;
    if (s_mem_to_reg) begin
      if ((s_funct3 == 3'b001 || s_funct3 == 3'b101) && s_alu_result[0])
        misaligned = 1'b1;
      else if (s_funct3 == 3'b010 && s_alu_result[1:0] != 2'b00)
        misaligned = 1'b1;
    end
  end

  assign s_trap = s_ebreak | s_illegal | misaligned | (s_mem_to_reg & bad_funct3);

  // Writeback source priority: jump link, then load data, then ALU.
  always_comb begin
    if (s_jump)
      WriteData = s_pc + 32'd4;
    else if (s_mem_to_reg)
      WriteData = load_data;
    else
      WriteData = s_alu_result;
  end

  assign WriteAddr      = s_rd_waddr;
  assign WriteEn        = s_valid & s_reg_write & (s_rd_waddr != 5'd0) & ~s_trap & running;
  assign o_retire_valid = s_valid & running;
  assign o_retire_pc    = s_pc;
  assign o_trap         = s_trap & s_valid;
  assign o_halt         = (state == HALT);
  assign o_instret      = instret;

  assign retire_ok = o_retire_valid & ~o_trap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= RUN;
      s_valid      <= 1'b0;
      s_pc         <= 32'h0000_0000;
      s_alu_result <= 32'h0000_0000;
      s_mem_rdata  <= 32'h0000_0000;
      s_funct3     <= 3'b000;
      s_mem_to_reg <= 1'b0;
      s_jump       <= 1'b0;
      s_reg_write  <= 1'b0;
      s_rd_waddr   <= 5'd0;
      s_ebreak     <= 1'b0;
      s_illegal    <= 1'b0;
      instret      <= '0;
    end else begin
      // A flush only discards the incoming instruction; a trap already held
      // in the stage still moves the machine to HALT below.
      s_valid      <= i_valid & ~i_flush & running;
      s_pc         <= i_pc;
      s_alu_result <= i_alu_result;
      s_mem_rdata  <= i_mem_rdata;
      s_funct3     <= i_funct3;
      s_mem_to_reg <= i_mem_to_reg;
      s_jump       <= i_jump;
      s_reg_write  <= i_reg_write;
      s_rd_waddr   <= i_rd_waddr;
      s_ebreak     <= i_ebreak;
      s_illegal    <= i_illegal;

      case (state)
        RUN:     if (s_valid & s_trap) state <= HALT;
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase

      if (retire_ok)
        instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback -- directed-vector bench for the writeback stage.
// Inputs are driven 1 ns after a rising edge and outputs are checked 1 ns
// after the edge that captured them.
// ---------------------------------------------------------------------------
module tb_writeback;

  localparam int INSTRET_W = 64;

  logic                 clk;
  logic                 rst;
  logic                 valid;
  logic                 flush;
  logic [31:0]          pc;
  logic [31:0]          alu_result;
  logic [31:0]          mem_rdata;
  logic [2:0]           funct3;
  logic                 mem_to_reg;
  logic                 jump;
  logic                 reg_write;
  logic [4:0]           rd_waddr;
  logic                 ebreak;
  logic                 illegal;
  logic [31:0]          write_data;
  logic [4:0]           write_addr;
  logic                 write_en;
  logic                 retire_valid;
  logic [31:0]          retire_pc;
  logic                 trap;
  logic                 halt;
  logic [INSTRET_W-1:0] instret;

  int checks = 0;
  int errors = 0;

  writeback #(.INSTRET_W(INSTRET_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (valid),
    .i_flush        (flush),
    .i_pc           (pc),
    .i_alu_result   (alu_result),
    .i_mem_rdata    (mem_rdata),
    .i_funct3       (funct3),
    .i_mem_to_reg   (mem_to_reg),
    .i_jump         (jump),
    .i_reg_write    (reg_write),
    .i_rd_waddr     (rd_waddr),
    .i_ebreak       (ebreak),
    .i_illegal      (illegal),
    .WriteData      (write_data),
    .WriteAddr      (write_addr),
    .WriteEn        (write_en),
    .o_retire_valid (retire_valid),
    .o_retire_pc    (retire_pc),
    .o_trap         (trap),
    .o_halt         (halt),
    .o_instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle_inputs();
    valid = 0; flush = 0; pc = 32'h0; alu_result = 32'h0; mem_rdata = 32'h0;
    funct3 = 3'b000; mem_to_reg = 0; jump = 0; reg_write = 0; rd_waddr = 5'd0;
    ebreak = 0; illegal = 0;
  endtask

  // Present an instruction, let it be captured, and land 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3);
    idle_inputs();
    valid = 1; pc = 32'h0000_0100; alu_result = addr; mem_rdata = 32'h80FF_7F01;
    funct3 = f3; mem_to_reg = 1; reg_write = 1; rd_waddr = 5'd5;
    tick();
  endtask

  task automatic all_zero(input string tag);
    check({tag, " WriteData"}, 64'(write_data), 64'h0);
    check({tag, " WriteAddr"}, 64'(write_addr), 64'h0);
    check({tag, " WriteEn"}, 64'(write_en), 64'h0);
    check({tag, " retire_valid"}, 64'(retire_valid), 64'h0);
    check({tag, " retire_pc"}, 64'(retire_pc), 64'h0);
    check({tag, " trap"}, 64'(trap), 64'h0);
    check({tag, " halt"}, 64'(halt), 64'h0);
    check({tag, " instret"}, instret, 64'h0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    // Drive junk during reset; nothing may leak to the outputs.
    valid = 1; reg_write = 1; rd_waddr = 5'd7; alu_result = 32'hDEAD_BEEF;
    tick();
    tick();
    all_zero("in reset");

    @(negedge clk);
    rst = 0;
    #1;
    all_zero("after release");

    // ADDI x3 = 5
    idle_inputs();
    valid = 1; pc = 32'h0000_0040; alu_result = 32'h0000_0005; reg_write = 1; rd_waddr = 5'd3;
    tick();
    check("addi WriteEn", 64'(write_en), 64'h1);
    check("addi WriteAddr", 64'(write_addr), 64'h3);
    check("addi WriteData", 64'(write_data), 64'h5);
    check("addi retire_valid", 64'(retire_valid), 64'h1);
    check("addi retire_pc", 64'(retire_pc), 64'h40);
    check("addi instret before", instret, 64'h0);
    idle_inputs();
    tick();
    check("bubble retire_valid", 64'(retire_valid), 64'h0);
    check("addi instret after", instret, 64'h1);

    // Loads from word 0x80FF_7F01
    load(32'h0000_2003, 3'b000);
    check("lb@3 WriteData", 64'(write_data), 64'hFFFF_FF80);
    check("lb@3 WriteEn", 64'(write_en), 64'h1);
    check("lb@3 instret", instret, 64'h1);
    load(32'h0000_2001, 3'b100);
    check("lbu@1 WriteData", 64'(write_data), 64'h0000_007F);
    check("lbu@1 instret", instret, 64'h2);
    load(32'h0000_2002, 3'b001);
    check("lh@2 WriteData", 64'(write_data), 64'hFFFF_80FF);
    load(32'h0000_2000, 3'b101);
    check("lhu@0 WriteData", 64'(write_data), 64'h0000_7F01);
    load(32'h0000_2000, 3'b010);
    check("lw WriteData", 64'(write_data), 64'h80FF_7F01);
    check("lw trap", 64'(trap), 64'h0);
    check("lw instret", instret, 64'h5);

    // JAL at the top of the address space: link wraps to 0
    idle_inputs();
    valid = 1; pc = 32'hFFFF_FFFC; alu_result = 32'h0000_1234; jump = 1; reg_write = 1; rd_waddr = 5'd1;
    tick();
    check("jal WriteData", 64'(write_data), 64'h0);
    check("jal WriteEn", 64'(write_en), 64'h1);
    check("jal WriteAddr", 64'(write_addr), 64'h1);
    check("jal instret", instret, 64'h6);

    // Write to x0 retires but is not issued
    idle_inputs();
    valid = 1; pc = 32'h0000_0200; alu_result = 32'h0000_0099; reg_write = 1; rd_waddr = 5'd0;
    tick();
    check("x0 WriteEn", 64'(write_en), 64'h0);
    check("x0 retire_valid", 64'(retire_valid), 64'h1);
    check("x0 instret", instret, 64'h7);

    // Flushed instruction, then a normal one
    idle_inputs();
    valid = 1; flush = 1; alu_result = 32'h0000_0011; reg_write = 1; rd_waddr = 5'd4;
    tick();
    check("flush retire_valid", 64'(retire_valid), 64'h0);
    check("flush WriteEn", 64'(write_en), 64'h0);
    check("flush instret", instret, 64'h8);
    idle_inputs();
    valid = 1; pc = 32'h0000_0300; alu_result = 32'h0000_0022; reg_write = 1; rd_waddr = 5'd4;
    tick();
    check("post-flush retire_valid", 64'(retire_valid), 64'h1);
    check("post-flush WriteData", 64'(write_data), 64'h22);
    check("post-flush instret", instret, 64'h8);

    // Misaligned LW traps; core halts afterwards
    idle_inputs();
    valid = 1; pc = 32'h0000_0400; alu_result = 32'h0000_1002; mem_rdata = 32'h1111_2222;
    funct3 = 3'b010; mem_to_reg = 1; reg_write = 1; rd_waddr = 5'd6;
    tick();
    check("mis-lw trap", 64'(trap), 64'h1);
    check("mis-lw retire_valid", 64'(retire_valid), 64'h1);
    check("mis-lw WriteEn", 64'(write_en), 64'h0);
    check("mis-lw halt", 64'(halt), 64'h0);
    check("mis-lw instret", instret, 64'h9);
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      valid = 1; pc = 32'h0000_0500; alu_result = 32'h0000_0033; reg_write = 1; rd_waddr = 5'd8;
      tick();
      check($sformatf("halt[%0d] halt", i), 64'(halt), 64'h1);
      check($sformatf("halt[%0d] WriteEn", i), 64'(write_en), 64'h0);
      check($sformatf("halt[%0d] retire_valid", i), 64'(retire_valid), 64'h0);
      check($sformatf("halt[%0d] instret", i), instret, 64'h9);
    end

    // Asynchronous reset between edges while halted
    #2;
    rst = 1;
    #1;
    all_zero("async reset");
    @(negedge clk);
    rst = 0;
    #1;
    all_zero("after 2nd release");
    idle_inputs();
    valid = 1; pc = 32'h0000_0600; alu_result = 32'h0000_0077; reg_write = 1; rd_waddr = 5'd9;
    tick();
    check("resume retire_valid", 64'(retire_valid), 64'h1);
    check("resume WriteEn", 64'(write_en), 64'h1);
    check("resume WriteData", 64'(write_data), 64'h77);
    check("resume halt", 64'(halt), 64'h0);
    idle_inputs();
    tick();
    check("resume instret", instret, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
